// File: rtl/mem_access_ctrl_pkg.sv
// Shared opcode constants and decode helpers for the MEM-stage
// data RAM sequencer.
package mem_access_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } acc_size_e;

    // Access size of an opcode; SZ_NONE marks unsupported opcodes.
    function automatic acc_size_e op_size(input logic [5:0] op);
        acc_size_e s;
        s = SZ_NONE;
        case (op)
            OP_LB, OP_LBU, OP_SB: s = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: s = SZ_HALF;
            OP_LW, OP_SW:         s = SZ_WORD;
            default:              s = SZ_NONE;
        endcase
        return s;
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and RAM port bundle.
// slave: controller view; master: MEM stage + RAM view.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              ReqValid;
    logic              ReqReady;
    logic [5:0]        ReqOpcode;
    logic [31:0]       ReqAddr;
    logic [31:0]       ReqWData;
    logic              RespValid;
    logic [31:0]       RespData;
    logic              ReqErr;
    logic              MemEn;
    logic [3:0]        MemWE;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWData;
    logic [31:0]       MemRData;

    modport slave (
        input  ReqValid, ReqOpcode, ReqAddr, ReqWData, MemRData,
        output ReqReady, RespValid, RespData, ReqErr,
        output MemEn, MemWE, MemAddr, MemWData
    );

    modport master (
        output ReqValid, ReqOpcode, ReqAddr, ReqWData, MemRData,
        input  ReqReady, RespValid, RespData, ReqErr,
        input  MemEn, MemWE, MemAddr, MemWData
    );
endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// Big-endian load alignment and sign/zero extension.
// Ports: i_rdata (RAM word), i_opcode, i_off (byte offset) -> o_data.
module mem_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [5:0]  i_opcode,
    input  logic [1:0]  i_off,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 is the most significant byte.
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];
    end

    always_comb begin
        o_data = i_rdata;
        case (i_opcode)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'd0, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer to the synchronous data RAM: one access at a time.
// Ports: clk, rst (sync, active-high), bus (request/response + RAM port).
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [5:0]  r_op;
    logic [1:0]  r_off;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_err;

    logic        w_accept;
    logic [1:0]  w_off;
    acc_size_e   w_size;
    logic        w_store;
    logic        w_misal;
    logic        w_legal;
    logic        w_mem_en;
    logic [3:0]  w_we;
    logic [31:0] w_wdata;
    logic [31:0] w_aligned;
    logic        w_unused;

    assign w_off    = bus.ReqAddr[1:0];
    assign w_size   = op_size(bus.ReqOpcode);
    assign w_store  = op_is_store(bus.ReqOpcode);
    assign w_misal  = ((w_size == SZ_HALF) && w_off[0])
                    || ((w_size == SZ_WORD) && (w_off != 2'd0));
    assign w_legal  = (w_size != SZ_NONE) && !w_misal;
    assign w_accept = (r_state == S_IDLE) && bus.ReqValid;

    // RAM side is combinational off the accept cycle, held quiet in reset.
    assign w_mem_en = !rst && w_accept && w_legal;

    always_comb begin
        w_we    = 4'b0000;
        w_wdata = 32'd0;
        if (w_mem_en && w_store) begin
            case (w_size)
                SZ_BYTE: begin
                    w_we    = 4'b1000 >> w_off;
                    w_wdata = {4{bus.ReqWData[7:0]}};
                end
                SZ_HALF: begin
                    w_we    = w_off[1] ? 4'b0011 : 4'b1100;
                    w_wdata = {2{bus.ReqWData[15:0]}};
                end
                default: begin
                    w_we    = 4'b1111;
                    w_wdata = bus.ReqWData;
                end
            endcase
        end
    end

    assign bus.MemEn    = w_mem_en;
    assign bus.MemWE    = w_we;
    assign bus.MemWData = w_wdata;
    assign bus.MemAddr  = bus.ReqAddr[ADDR_W+1:2];
    assign w_unused     = ^bus.ReqAddr[31:ADDR_W+2];

    mem_load_align u_align (
        .i_rdata  (bus.MemRData),
        .i_opcode (r_op),
        .i_off    (r_off),
        .o_data   (w_aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_op         <= 6'd0;
            r_off        <= 2'd0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    r_resp_data  <= 32'd0;
                    r_err        <= 1'b0;
                    if (w_accept) begin
                        r_op  <= bus.ReqOpcode;
                        r_off <= w_off;
                        if (!w_legal) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_err        <= 1'b1;
                        end else if (w_store) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= S_RD_WAIT;
                            r_cnt   <= 2'd1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == LAT) begin
                        r_state      <= S_RESP;
                        r_cnt        <= 2'd0;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_aligned;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_data  <= 32'd0;
                    r_err        <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ReqReady  = (r_state == S_IDLE);
    assign bus.RespValid = r_resp_valid;
    assign bus.RespData  = r_resp_data;
    assign bus.ReqErr    = r_err;
endmodule
